conv_window_buffer: RTL

Streaming sliding-window generator at the front of the CNN pipeline, between the camera pixel source and the first convolution stage. Accepts one raster-ordered fixed-point pixel per valid cycle, holds the previous K-1 image rows in line buffers, and presents the full KxK neighbourhood ending at the current pixel as a flat vector. The convolution stage consumes it together with the window's top-left screen coordinate.

---
 rtl/conv_window_buffer_pkg.sv | 15 +
 rtl/conv_window_buffer_if.sv | 29 ++
 rtl/conv_window_buffer_line_delay.sv | 26 ++
 rtl/conv_window_buffer.sv | 118 +++++++++++
 4 files changed

// File: rtl/conv_window_buffer_pkg.sv
// Shared constants and types for the sliding-window front end of the CNN pipeline.
// Defaults match the network parameter header; coordinate widths are derived here.
package conv_window_buffer_pkg;

  localparam int unsigned DEF_PIXEL_W = 9;
  localparam int unsigned DEF_IMG_W   = 36;
  localparam int unsigned DEF_IMG_H   = 36;
  localparam int unsigned DEF_K       = 3;
  localparam int unsigned DEF_X_W     = $clog2(DEF_IMG_W);
  localparam int unsigned DEF_Y_W     = $clog2(DEF_IMG_H);
  localparam int unsigned DEF_WIN_W   = DEF_K * DEF_K * DEF_PIXEL_W;

  typedef logic [DEF_PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out bundle between camera source, window buffer and conv stage.
interface conv_window_buffer_if
  import conv_window_buffer_pkg::*;
#(
  parameter int unsigned PIXEL_W = DEF_PIXEL_W,
  parameter int unsigned K       = DEF_K,
  parameter int unsigned X_W     = DEF_X_W,
  parameter int unsigned Y_W     = DEF_Y_W
);

  logic                     sof;
  logic                     pixel_valid;
  logic [PIXEL_W-1:0]       pixel_in;
  logic                     window_valid;
  logic [K*K*PIXEL_W-1:0]   window;
  logic [X_W-1:0]           win_x;
  logic [Y_W-1:0]           win_y;

  modport master (
    output sof, pixel_valid, pixel_in,
    input  window_valid, window, win_x, win_y
  );

  modport slave (
    input  sof, pixel_valid, pixel_in,
    output window_valid, window, win_x, win_y
  );

endinterface

// File: rtl/conv_window_buffer_line_delay.sv
// Enable-gated DEPTH-stage delay line holding one image row of pixels.
module line_delay #(
  parameter int unsigned DEPTH = 36,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (en) begin
      sr_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK window generator: line buffers plus shift array, one window per
// accepted pixel whose position completes a full in-frame neighbourhood.
module conv_window_buffer
  import conv_window_buffer_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned K       = DEF_K,
  parameter int unsigned PIXEL_W = DEF_PIXEL_W,
  parameter int unsigned X_W     = DEF_X_W,
  parameter int unsigned Y_W     = DEF_Y_W
) (
  input  logic               clock,
  input  logic               reset,
  conv_window_buffer_if.slave bus
);

  localparam int unsigned WIN_W = K * K * PIXEL_W;

  logic [X_W-1:0]     col_q, col_d, cur_col;
  logic [Y_W-1:0]     row_q, row_d, cur_row;
  logic [PIXEL_W-1:0] lb_in  [K-1];
  logic [PIXEL_W-1:0] lb_out [K-1];
  logic [PIXEL_W-1:0] sa_q   [K][K];
  logic [PIXEL_W-1:0] sa_d   [K][K];
  logic               window_valid_q, window_valid_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [X_W-1:0]     win_x_q, win_x_d;
  logic [Y_W-1:0]     win_y_q, win_y_d;

  // Buffer i delays the pixel stream by (i+1) rows; each feeds the next.
  for (genvar i = 0; i < int'(K) - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_in[i] = bus.pixel_in;
    end else begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    line_delay #(
      .DEPTH (IMG_W),
      .WIDTH (PIXEL_W)
    ) u_line_delay (
      .clock (clock),
      .reset (reset),
      .en    (bus.pixel_valid),
      .din   (lb_in[i]),
      .dout  (lb_out[i])
    );
  end

  // Position tracking, shift-array update and window capture.
  always_comb begin
    cur_col        = bus.sof ? '0 : col_q;
    cur_row        = bus.sof ? '0 : row_q;
    col_d          = col_q;
    row_d          = row_q;
    sa_d           = sa_q;
    window_valid_d = 1'b0;
    window_d       = window_q;
    win_x_d        = win_x_q;
    win_y_d        = win_y_q;

    if (bus.pixel_valid) begin
      if (cur_col == X_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == Y_W'(IMG_H - 1)) ? '0 : cur_row + Y_W'(1);
      end else begin
        col_d = cur_col + X_W'(1);
        row_d = cur_row;
      end

      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) sa_d[r][c] = sa_q[r][c+1];
      end
      for (int unsigned r = 0; r < K - 1; r++) sa_d[r][K-1] = lb_out[K-2-r];
      sa_d[K-1][K-1] = bus.pixel_in;

      // Stale line-buffer data after a mid-frame sof stays hidden behind this gate.
      if (cur_col >= X_W'(K - 1) && cur_row >= Y_W'(K - 1)) begin
        window_valid_d = 1'b1;
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K; c++) begin
            window_d[(r*K+c)*PIXEL_W +: PIXEL_W] = sa_d[r][c];
          end
        end
        win_x_d = cur_col - X_W'(K - 1);
        win_y_d = cur_row - Y_W'(K - 1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      window_q       <= '0;
      win_x_q        <= '0;
      win_y_q        <= '0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) sa_q[r][c] <= '0;
      end
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_q <= window_valid_d;
      window_q       <= window_d;
      win_x_q        <= win_x_d;
      win_y_q        <= win_y_d;
      sa_q           <= sa_d;
    end
  end

  assign bus.window_valid = window_valid_q;
  assign bus.window       = window_q;
  assign bus.win_x        = win_x_q;
  assign bus.win_y        = win_y_q;

endmodule
